fp32_accum: RTL
===============

Name: fp32_accum

Overview:
- Sequential single-precision (IEEE-754 binary32) accumulator that sits directly downstream of the combinational FP32 multiplier.
- Consumes a stream of products over a valid/ready handshake and sums them into an internal register.
- On the beat flagged `in_last`, presents the total and clears itself, ready for the next stream.
- Together with the multiplier it forms a dot-product / MAC datapath.

Parameters:
- MAX_NORM, 24, upper bound on left-normalize cycles per addition (must be ≥ 24).

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  product word valid.
- in_data  input  32  FP32 operand (multiplier output).
- in_last  input  1  marks final operand of a stream; sampled with in_data.
- in_ready  output  1  high only in IDLE; transfer occurs when in_valid && in_ready.
- out_valid  output  1  accumulated result valid.
- out_data  output  32  FP32 sum of the stream.
- out_ready  input  1  consumer accepts result when out_valid && out_ready.

Behaviour:
- Reset (synchronous, active-high, rst sampled high on a clock edge):
  - Next state IDLE; acc=0; out_valid=0; out_data=0; in_ready=1.
  - Applies from any state and aborts any in-flight add; the pending operand is discarded.
- FSM states: IDLE → ALIGN → ADD → NORM → (IDLE | DONE).
  - IDLE: in_ready=1. On transfer, latch in_data as B, acc as A, in_last as last_r; go to ALIGN.
  - ALIGN (1 cycle):
    - Unpack to sign, 8-bit exponent, 24-bit significand with hidden 1. Exp==0 operands are treated as exact zero: significand 0, denormals flushed.
    - Swap so A has the larger magnitude (exponent, then significand).
    - Right-shift B significand by exp difference; a difference ≥ 25 yields 0. Shifted-out bits are discarded, i.e. truncation (round toward zero).
  - ADD (1 cycle):
    - Equal signs: 25-bit sum. Differing signs: A−B (never negative).
    - Result sign = sign of A. Working exponent = exp of A.
  - NORM: iterative, one action per cycle.
    - Sum==0: result +0 (0x00000000); finish immediately.
    - Bit 24 set: shift right 1, exp+1, finish.
    - Bit 23 set: finish.
    - Otherwise: shift left 1, exp−1, repeat.
    - Exp reaching ≥255 → ±Inf (exp 255, mantissa 0). Exp reaching ≤0 → +0 (flush).
    - Loop is bounded by MAX_NORM; on bound, result is +0.
    - On finish: acc ← packed result. If last_r: out_data ← result, out_valid ← 1, acc ← 0, go to DONE; else go to IDLE.
  - Special operands: if either operand has exp==255, result = that operand (A preferred) with mantissa cleared, i.e. signed Inf. NaN is not propagated. This bypasses NORM arithmetic but still takes the ALIGN/ADD/NORM cycles, with a single NORM cycle.
  - DONE: in_ready=0; out_valid=1; out_data held stable. On out_ready, out_valid ← 0 and go to IDLE.
- Latency (operand accepted at cycle T):
  - ALIGN at T+1, ADD at T+2, NORM at T+3…T+3+k, where k = number of left shifts.
  - Non-last beat: in_ready high again at T+4+k.
  - Last beat: out_valid rises at T+4+k.
  - Throughput is one operand per 4+k cycles.
- in_valid while not in_ready is ignored; the source must hold data stable.
- First operand of a stream adds to acc=0 and passes through unchanged, except for denormal flush.

Test Plan:
- Stream 0x41C80000 (25.0), then 0x42460000 (49.5, last), out_ready=1 → single out_valid pulse, out_data=0x42950000 (74.5); acc cleared; a following stream 0x3F800000 (last) → 0x3F800000.
- 0xC1C80000 (−25.0), then 0x41C80000 (last) → out_data=0x00000000; NORM exits on zero in one cycle.
- 0x3F800000 (1.0), then 0x30800000 (2^-30, last) → out_data=0x3F800000 (B fully shifted out).
- 0x3FC00000 (1.5), then 0xBFBFFFFF (last) → out_data=0x34000000; k=23, so out_valid asserts exactly 27 cycles after the last beat is accepted.
- 0x7F7FFFFF twice (second last) → out_data=0x7F800000 (+Inf overflow).
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles in DONE → out_valid=1, out_data constant, in_ready=0 throughout.
  - Assert rst for one cycle during NORM → next cycle out_valid=0, out_data=0, in_ready=1, acc=0.
  - A subsequent stream 0x40A00000 (last) → 0x40A00000.

Source files
------------

// File: rtl/fp32_accum.sv
// fp32_accum: sequential FP32 stream accumulator (truncating, denormals flushed), valid/ready in and out.
module fp32_accum #(
  parameter int MAX_NORM = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready
);
  localparam int CW = $clog2(MAX_NORM + 1);
  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;
  state_t state;
  logic [31:0] a, b, acc, spec, spec_c, res;
  logic [23:0] ma, mb, ma_c, mb_c, hi_m, lo_m, lo_sh;
  logic [7:0] ea, ea_c, eb_c, hi_e, lo_e, d, ex;
  logic [24:0] sum;
  logic [CW-1:0] cnt;
  logic last_r, sp, sign, sub, sw, hi_s, lo_s, is_sp, fin, ovf;
  always_comb begin
    ea_c = a[30:23];
    eb_c = b[30:23];
    ma_c = ea_c == 8'd0 ? 24'd0 : {1'b1, a[22:0]};
    mb_c = eb_c == 8'd0 ? 24'd0 : {1'b1, b[22:0]};
    sw = {eb_c, mb_c} > {ea_c, ma_c};
    hi_e = sw ? eb_c : ea_c;
    lo_e = sw ? ea_c : eb_c;
    hi_m = sw ? mb_c : ma_c;
    lo_m = sw ? ma_c : mb_c;
    hi_s = sw ? b[31] : a[31];
    lo_s = sw ? a[31] : b[31];
    d = hi_e - lo_e;
    lo_sh = d >= 8'd25 ? 24'd0 : lo_m >> d;
    is_sp = ea_c == 8'hff || eb_c == 8'hff;
    spec_c = ea_c == 8'hff ? {a[31], 8'hff, 23'd0} : {b[31], 8'hff, 23'd0};
  end
  // One NORM decision per cycle; anything not finishing here is a left shift.
  always_comb begin
    ovf = ex >= 8'd254;
    fin = sp || sum == 25'd0 || sum[24] || sum[23] || ex <= 8'd1 || cnt == CW'(MAX_NORM);
    res = sp ? spec
        : sum == 25'd0 ? 32'd0
        : sum[24] ? (ovf ? {sign, 8'hff, 23'd0} : {sign, ex + 8'd1, sum[23:1]})
        : sum[23] ? {sign, ex, sum[22:0]}
        : 32'd0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= 32'd0;
      out_valid <= 1'b0;
      out_data <= 32'd0;
      in_ready <= 1'b1;
      a <= 32'd0;
      b <= 32'd0;
      last_r <= 1'b0;
      ma <= 24'd0;
      mb <= 24'd0;
      ea <= 8'd0;
      sign <= 1'b0;
      sub <= 1'b0;
      sp <= 1'b0;
      spec <= 32'd0;
      sum <= 25'd0;
      ex <= 8'd0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a <= acc;
          b <= in_data;
          last_r <= in_last;
          in_ready <= 1'b0;
          state <= ALIGN;
        end
        ALIGN: begin
          ma <= hi_m;
          mb <= lo_sh;
          ea <= hi_e;
          sign <= hi_s;
          sub <= hi_s ^ lo_s;
          sp <= is_sp;
          spec <= spec_c;
          state <= ADD;
        end
        ADD: begin
          sum <= sub ? {1'b0, ma} - {1'b0, mb} : {1'b0, ma} + {1'b0, mb};
          ex <= ea;
          cnt <= '0;
          state <= NORM;
        end
        NORM: if (fin) begin
          acc <= last_r ? 32'd0 : res;
          if (last_r) begin
            out_data <= res;
            out_valid <= 1'b1;
            state <= DONE;
          end else begin
            in_ready <= 1'b1;
            state <= IDLE;
          end
        end else begin
          sum <= sum << 1;
          ex <= ex - 8'd1;
          cnt <= cnt + 1'b1;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
